// File: rtl/eth_rxstatem_hdr.sv
// Receive-side MII frame state machine with header field capture.
// Walks Idle/Preamble/SFD/DA/SA/Length/Data/Drop using the counter stage's
// ByteCnt/Rx_NibCnt, assembles DA/SA/length-type, and flags frame end/abort.
module eth_rxstatem_hdr #(
  parameter int unsigned PRE_LAST   = 13,
  parameter int unsigned ADDR_BYTES = 6
) (
  input  logic                        MRxClk,
  input  logic                        Reset,
  input  logic                        MRxDV,
  input  logic [3:0]                  MRxD,
  input  logic                        Transmitting,
  input  logic                        IFGCounterEq24,
  input  logic [15:0]                 ByteCnt,
  input  logic                        Rx_NibCnt,
  input  logic                        ByteCntMaxFrame,
  output logic                        StateIdle,
  output logic                        StateDrop,
  output logic                        StatePreamble,
  output logic                        StateSFD,
  output logic                        StateDA,
  output logic                        StateSA,
  output logic                        StateLength,
  output logic [1:0]                  StateData,
  output logic [8*ADDR_BYTES-1:0]     RxDA,
  output logic [8*ADDR_BYTES-1:0]     RxSA,
  output logic [15:0]                 RxLenType,
  output logic                        HdrValid,
  output logic                        RxEndFrame,
  output logic                        RxAbort
);

  localparam int unsigned ADDR_W = 8 * ADDR_BYTES;

  // One-hot encoding so each State* output is a register bit with no decode.
  typedef enum logic [8:0] {
    S_IDLE  = 9'b0_0000_0001,
    S_DROP  = 9'b0_0000_0010,
    S_PRE   = 9'b0_0000_0100,
    S_SFD   = 9'b0_0000_1000,
    S_DA    = 9'b0_0001_0000,
    S_SA    = 9'b0_0010_0000,
    S_LEN   = 9'b0_0100_0000,
    S_DATA0 = 9'b0_1000_0000,
    S_DATA1 = 9'b1_0000_0000
  } state_t;

  state_t              r_state;
  logic                r_hdr_valid;
  logic                r_end_frame;
  logic                r_abort;
  logic [ADDR_W-1:0]   r_da;
  logic [ADDR_W-1:0]   r_sa;
  logic [15:0]         r_len;

  logic w_eq5;
  logic w_eqd;
  logic w_bc0;
  logic w_bc1;
  logic w_pre_last;
  logic w_addr_last;

  assign w_eq5       = (MRxD == 4'h5);
  assign w_eqd       = (MRxD == 4'hD);
  assign w_bc0       = (ByteCnt == 16'd0);
  assign w_bc1       = (ByteCnt == 16'd1);
  assign w_pre_last  = (ByteCnt == 16'(PRE_LAST));
  assign w_addr_last = Rx_NibCnt & (ByteCnt == 16'(ADDR_BYTES - 1));

  // Frame FSM: state transitions plus the end/abort/header-valid pulses.
  always_ff @(posedge MRxClk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_hdr_valid <= 1'b0;
      r_end_frame <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_hdr_valid <= 1'b0;
      r_end_frame <= 1'b0;
      r_abort     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (MRxDV & w_eq5 & IFGCounterEq24 & ~Transmitting) r_state <= S_PRE;
          else if (MRxDV)                                      r_state <= S_DROP;
        end
        S_DROP: begin
          if (!MRxDV) r_state <= S_IDLE;
        end
        S_PRE: begin
          if (!MRxDV)      begin r_state <= S_IDLE; r_abort <= 1'b1; end
          else if (!w_eq5) begin r_state <= S_DROP; r_abort <= 1'b1; end
          else if (w_pre_last) r_state <= S_SFD;
        end
        S_SFD: begin
          if (!MRxDV)                begin r_state <= S_IDLE; r_abort <= 1'b1; end
          else if (w_bc0 & ~w_eq5)   begin r_state <= S_DROP; r_abort <= 1'b1; end
          else if (w_bc1 & ~w_eqd)   begin r_state <= S_DROP; r_abort <= 1'b1; end
          else if (w_bc1)            r_state <= S_DA;
        end
        S_DA: begin
          if (!MRxDV)           begin r_state <= S_IDLE; r_abort <= 1'b1; end
          else if (w_addr_last) r_state <= S_SA;
        end
        S_SA: begin
          if (!MRxDV)           begin r_state <= S_IDLE; r_abort <= 1'b1; end
          else if (w_addr_last) r_state <= S_LEN;
        end
        S_LEN: begin
          if (!MRxDV)                begin r_state <= S_IDLE; r_abort <= 1'b1; end
          else if (Rx_NibCnt & w_bc1) begin r_state <= S_DATA0; r_hdr_valid <= 1'b1; end
        end
        S_DATA0: begin
          if (!MRxDV) begin r_state <= S_IDLE; r_end_frame <= 1'b1; end
          else        r_state <= S_DATA1;
        end
        S_DATA1: begin
          if (!MRxDV)               begin r_state <= S_IDLE; r_end_frame <= 1'b1; end
          else if (ByteCntMaxFrame) begin r_state <= S_DROP; r_abort <= 1'b1; end
          else                      r_state <= S_DATA0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Header capture: nibble-wise writes into DA/SA/length; kept across aborts.
  always_ff @(posedge MRxClk) begin
    if (Reset) begin
      r_da  <= '0;
      r_sa  <= '0;
      r_len <= '0;
    end else if (MRxDV) begin
      for (int k = 0; k < int'(ADDR_BYTES); k++) begin
        if (ByteCnt == 16'(k)) begin
          if (r_state == S_DA) begin
            if (Rx_NibCnt) r_da[ADDR_W-1-8*k -: 4] <= MRxD;
            else           r_da[ADDR_W-5-8*k -: 4] <= MRxD;
          end
          if (r_state == S_SA) begin
            if (Rx_NibCnt) r_sa[ADDR_W-1-8*k -: 4] <= MRxD;
            else           r_sa[ADDR_W-5-8*k -: 4] <= MRxD;
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        if ((ByteCnt == 16'(k)) && (r_state == S_LEN)) begin
          if (Rx_NibCnt) r_len[15-8*k -: 4] <= MRxD;
          else           r_len[11-8*k -: 4] <= MRxD;
        end
      end
    end
  end

  assign StateIdle     = r_state[0];
  assign StateDrop     = r_state[1];
  assign StatePreamble = r_state[2];
  assign StateSFD      = r_state[3];
  assign StateDA       = r_state[4];
  assign StateSA       = r_state[5];
  assign StateLength   = r_state[6];
  assign StateData     = r_state[8:7];
  assign RxDA          = r_da;
  assign RxSA          = r_sa;
  assign RxLenType     = r_len;
  assign HdrValid      = r_hdr_valid;
  assign RxEndFrame    = r_end_frame;
  assign RxAbort       = r_abort;

endmodule
